// File: rtl/flipflop_bank.sv
// Multi-channel clocked storage bank: WIDTH bits sharing one clock and a run-time
// D / T / JK / SR mode, with parametrised SR conflict resolution and conflict status.
module flipflop_bank #(
  parameter int                 WIDTH       = 8,
  parameter int                 SR_CONFLICT = 0,
  parameter int                 CNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sync_clear,
  input  logic                  clr_status,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      Q_bar,
  output logic                  conflict,
  output logic [WIDTH-1:0]      conflict_mask,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     q_q, q_d;
  logic                 conflict_q, conflict_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     hit;

  assign hit = (mode == MODE_SR) ? (a & b) : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    q_d        = q_q;
    conflict_d = 1'b0;
    mask_d     = mask_q;
    count_d    = count_q;

    if (sync_clear) begin
      q_d     = RESET_VALUE;
      mask_d  = '0;
      count_d = '0;
    end else begin
      if (clr_status) begin
        mask_d  = '0;
        count_d = '0;
      end

      if (enable) begin
        for (int i = 0; i < WIDTH; i++) begin
          unique case (mode)
            MODE_D:  q_d[i] = a[i];
            MODE_T:  q_d[i] = q_q[i] ^ a[i];
            MODE_JK: begin
              unique case ({a[i], b[i]})
                2'b00:   q_d[i] = q_q[i];
                2'b01:   q_d[i] = 1'b0;
                2'b10:   q_d[i] = 1'b1;
                default: q_d[i] = ~q_q[i];
              endcase
            end
            default: begin
              unique case ({a[i], b[i]})
                2'b00: q_d[i] = q_q[i];
                2'b01: q_d[i] = 1'b0;
                2'b10: q_d[i] = 1'b1;
                default: begin
                  // S=R=1 resolves to a defined value chosen at elaboration
                  case (SR_CONFLICT)
                    1:       q_d[i] = 1'b1;
                    2:       q_d[i] = 1'b0;
                    3:       q_d[i] = ~q_q[i];
                    default: q_d[i] = q_q[i];
                  endcase
                end
              endcase
            end
          endcase
        end

        // One count per conflicting edge, however many bits collide; a same-edge
        // clr_status has already zeroed the status, so the new event wins.
        if (|hit) begin
          conflict_d = 1'b1;
          mask_d     = mask_d | hit;
          if (count_d != CNT_MAX) count_d = count_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of the others.
    if (!reset_n) begin
      q_q        <= RESET_VALUE;
      conflict_q <= 1'b0;
      mask_q     <= '0;
      count_q    <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
    end
  end

  assign Q              = q_q;
  assign Q_bar          = ~q_q;
  assign conflict       = conflict_q;
  assign conflict_mask  = mask_q;
  assign conflict_count = count_q;

endmodule

// File: tb/tb_flipflop_bank.sv
// Self-checking bench for flipflop_bank: four instances (one per SR_CONFLICT policy)
// driven in parallel and compared against a per-bit behavioural model.
module tb_flipflop_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       sync_clear = 1'b0;
  logic       clr_status = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [7:0] q_o [4];
  logic [7:0] qb_o [4];
  logic       conf_o [4];
  logic [7:0] mask_o [4];
  logic [7:0] cnt_o [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 0) ? 8 : 2;
    logic [CW-1:0] cnt_w;
    flipflop_bank #(
      .WIDTH(8), .SR_CONFLICT(g), .CNT_WIDTH(CW), .RESET_VALUE(RV)
    ) u_dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .sync_clear(sync_clear),
      .clr_status(clr_status), .mode(mode), .a(a), .b(b),
      .Q(q_o[g]), .Q_bar(qb_o[g]), .conflict(conf_o[g]),
      .conflict_mask(mask_o[g]), .conflict_count(cnt_w)
    );
    assign cnt_o[g] = 8'(cnt_w);
  end

  // Reference model state, one entry per instance.
  logic [7:0] mq [4];
  logic       mconf [4];
  logic [7:0] mmask [4];
  int         mcnt [4];
  int         cmax [4] = '{255, 3, 3, 3};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_q(int k, logic [7:0] q);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        2'd0: n[i] = a[i];
        2'd1: n[i] = q[i] ^ a[i];
        2'd2: n[i] = (a[i] && b[i]) ? ~q[i] : a[i] ? 1'b1 : b[i] ? 1'b0 : q[i];
        default: begin
          if (a[i] && b[i])
            n[i] = (k == 1) ? 1'b1 : (k == 2) ? 1'b0 : (k == 3) ? ~q[i] : q[i];
          else
            n[i] = a[i] ? 1'b1 : b[i] ? 1'b0 : q[i];
        end
      endcase
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k] = RV; mconf[k] = 1'b0; mmask[k] = '0; mcnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic hit;
    hit = enable && (mode == 2'd3) && ((a & b) != 0);
    for (int k = 0; k < 4; k++) begin
      if (sync_clear) begin
        mq[k] = RV; mconf[k] = 1'b0; mmask[k] = '0; mcnt[k] = 0;
      end else begin
        if (enable) mq[k] = next_q(k, mq[k]);
        if (clr_status) begin mmask[k] = '0; mcnt[k] = 0; end
        mconf[k] = hit;
        if (hit) begin
          mmask[k] = mmask[k] | (a & b);
          mcnt[k]  = (mcnt[k] < cmax[k]) ? mcnt[k] + 1 : cmax[k];
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.u%0d.q", tag, k),     q_o[k],        mq[k]);
      check($sformatf("%s.u%0d.qbar", tag, k),  qb_o[k],       ~mq[k]);
      check($sformatf("%s.u%0d.conf", tag, k),  8'(conf_o[k]), 8'(mconf[k]));
      check($sformatf("%s.u%0d.mask", tag, k),  mask_o[k],     mmask[k]);
      check($sformatf("%s.u%0d.cnt", tag, k),   cnt_o[k],      8'(mcnt[k]));
    end
  endtask

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input string tag, input logic en, input logic [1:0] md,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic sc = 1'b0, input logic cs = 1'b0);
    enable = en; mode = md; a = av; b = bv; sync_clear = sc; clr_status = cs;
    @(posedge clock);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("rst");
    check("rst_q_const", q_o[0], 8'hA5);
    check("rst_qb_const", qb_o[0], 8'h5A);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Asynchronous reset mid-operation, then first D update after release.
    step("load3c", 1, 2'd0, 8'h3C, 8'h00);
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    check("async_q_const", q_o[0], 8'hA5);
    #1 reset_n = 1'b1;
    step("d_ff", 1, 2'd0, 8'hFF, 8'h00);
    check("d_ff_const", q_o[0], 8'hFF);

    // SR sequence on bit 0.
    step("clr0", 1, 2'd0, 8'h00, 8'h00);
    step("sr_set", 1, 2'd3, 8'h01, 8'h00);
    check("sr_set_const", q_o[0], 8'h01);
    step("sr_hold1", 1, 2'd3, 8'h00, 8'h00);
    step("sr_rst", 1, 2'd3, 8'h00, 8'h01);
    check("sr_rst_const", q_o[0], 8'h00);
    step("sr_hold0", 1, 2'd3, 8'h00, 8'h00);

    // SR conflicts with hold policy, sticky mask and counter.
    step("load0f", 1, 2'd0, 8'h0F, 8'h00);
    step("conf81", 1, 2'd3, 8'h81, 8'h81);
    check("conf81_q_const", q_o[0], 8'h0F);
    check("conf81_mask_const", mask_o[0], 8'h81);
    step("conf_drop", 1, 2'd3, 8'h00, 8'h00);
    check("conf_pulse_const", 8'(conf_o[0]), 8'h00);
    step("conf02", 1, 2'd3, 8'h02, 8'h02);
    check("conf02_mask_const", mask_o[0], 8'h83);
    check("conf02_cnt_const", cnt_o[0], 8'd2);

    // Per-policy resolution from 0F with a=b=FF.
    step("load0f_b", 1, 2'd0, 8'h0F, 8'h00);
    step("conf_ff", 1, 2'd3, 8'hFF, 8'hFF);
    check("pol1_const", q_o[1], 8'hFF);
    check("pol2_const", q_o[2], 8'h00);
    check("pol3_const", q_o[3], 8'hF0);

    // JK toggle and T with enable gating.
    step("load55", 1, 2'd0, 8'h55, 8'h00);
    step("jk_tog", 1, 2'd2, 8'hFF, 8'hFF);
    check("jk_tog_const", q_o[0], 8'hAA);
    step("t_en1", 1, 2'd1, 8'h0F, 8'h00);
    check("t_en1_const", q_o[0], 8'hA5);
    step("t_en0", 0, 2'd1, 8'h0F, 8'h00);
    step("t_en1b", 1, 2'd1, 8'h0F, 8'h00);
    check("t_en1b_const", q_o[0], 8'hAA);

    // Saturation with CNT_WIDTH=2, then clr_status and sync_clear racing a conflict.
    step("stclr", 0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      step($sformatf("sat%0d", n), 1, 2'd3, 8'h10, 8'h10);
      check($sformatf("sat%0d_const", n), cnt_o[1], (n < 3) ? 8'(n + 1) : 8'd3);
    end
    step("clr_race", 1, 2'd3, 8'h04, 8'h04, 1'b0, 1'b1);
    check("clr_race_cnt_const", cnt_o[1], 8'd1);
    check("clr_race_mask_const", mask_o[1], 8'h04);
    step("sc_race", 1, 2'd3, 8'h04, 8'h04, 1'b1, 1'b0);
    check("sc_race_cnt_const", cnt_o[1], 8'd0);
    check("sc_race_q_const", q_o[1], 8'hA5);

    // Randomised traffic with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all("rnd_rst");
        #1 reset_n = 1'b1;
      end
      step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flipflop_bank.md
Name: flipflop_bank

Overview:
- Parametrised, multi-channel generalisation of the single clocked SR flip-flop.
- WIDTH independent storage bits share one clock and a run-time mode select: D, T, JK or SR.
- Resolution of the SR S=R=1 case is a parameter rather than undefined behaviour.
- Illegal-input events are reported through a registered pulse, a sticky per-bit mask and a saturating event counter.
- Used as the generic state-holding element beneath the latches/ flip-flop library and its testbenches.

Parameters:
- WIDTH, 8, number of storage bits (channels); legal range 1..64.
- SR_CONFLICT, 0, per-bit action when mode=SR and a=b=1: 0 hold, 1 set wins, 2 reset wins, 3 toggle.
- CNT_WIDTH, 8, width of the conflict event counter; legal range 1..32.
- RESET_VALUE, 0, WIDTH-bit value loaded into Q on reset and on sync_clear.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  clock enable for Q updates and conflict detection.
- sync_clear  input  1  synchronous clear of Q and all status.
- clr_status  input  1  synchronous clear of the status outputs only.
- mode  input  2  00 D, 01 T, 10 JK, 11 SR; shared by all bits.
- a  input  WIDTH  per-bit D / T / J / S, according to mode.
- b  input  WIDTH  per-bit K (JK) or R (SR); ignored in D and T modes.
- Q  output  WIDTH  stored state.
- Q_bar  output  WIDTH  bitwise complement of Q.
- conflict  output  1  one-cycle pulse following an SR conflict edge.
- conflict_mask  output  WIDTH  sticky record of the bits that have seen an SR conflict.
- conflict_count  output  CNT_WIDTH  saturating count of edges on which a conflict occurred.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Q=RESET_VALUE, Q_bar=~RESET_VALUE.
  - conflict=0, conflict_mask=0, conflict_count=0.
  - Outputs take these values immediately, without waiting for a clock edge.
  - Release of reset is synchronous in effect: the first update happens on the first rising edge after reset_n=1.
- Priority on each rising edge: reset_n > sync_clear > enable.
  - sync_clear=1 gives the reset values above; any same-cycle conflict is ignored.
- Q_bar is purely combinational ~Q. Q===Q_bar never occurs in any mode, including SR with a=b=1.
- enable=0: Q holds, conflict=0, mask and count hold (clr_status still acts).
- enable=1, per-bit next state, with latency 1 (new Q visible after the edge):
  - D: Q<=a.
  - T: Q<=Q^a.
  - JK:
    - 00 hold, 01 reset, 10 set.
    - 11 toggle; this is legal and never flags a conflict.
  - SR (a=S, b=R):
    - 00 hold, 10 set, 01 reset.
    - 11 resolved per SR_CONFLICT and flagged as a conflict.
- Conflict detection is live only when enable=1, mode=11, sync_clear=0 and (a&b)!=0.
  - conflict<=1 for exactly one cycle per such edge; it is registered, so it aligns with the updated Q.
  - conflict_mask<=conflict_mask|(a&b).
  - conflict_count increments by exactly 1 per conflicting edge, regardless of how many bits conflict.
  - conflict_count saturates at 2^CNT_WIDTH-1 and does not wrap.
- clr_status=1:
  - conflict, mask and count clear; Q is unaffected.
  - If a conflict occurs on the same edge, the new event wins: conflict=1, mask=a&b, count=1.
- Mode changes take effect on the same edge at which they are sampled. No state depends on the previous mode.
- a, b and mode must be stable around the rising edge. No internal synchronisers are provided.

Test Plan:
- Reset mid-operation (WIDTH=8, RESET_VALUE=8'hA5): with Q=8'h3C, drive reset_n=0 between edges -> Q=8'hA5 and Q_bar=8'h5A at once, status cleared; after release, the first edge with D mode and a=8'hFF -> Q=8'hFF.
- SR sequence on bit 0: S=1 -> Q[0]=1; S=R=0 -> holds 1; R=1 -> 0; hold -> 0. Q_bar is the complement throughout and conflict stays 0.
- SR conflict, SR_CONFLICT=0: Q=8'h0F, a=b=8'h81 -> Q=8'h0F, conflict pulses for 1 cycle, mask=8'h81, count=1. Second conflict with a=b=8'h02 -> mask=8'h83, count=2.
- SR_CONFLICT variants from Q=8'h0F with a=b=8'hFF: 1 -> 8'hFF; 2 -> 8'h00; 3 -> 8'hF0.
- JK and T: JK with a=b=8'hFF from 8'h55 -> 8'hAA, conflict=0. T with a=8'h0F, enable toggled 1,0,1 -> 8'hA5, hold, 8'hAA.
- Saturation and clear (CNT_WIDTH=2): 5 consecutive conflict edges -> count 1,2,3,3,3. Then clr_status together with a conflict -> count=1. Then sync_clear together with a conflict -> count=0, Q=RESET_VALUE.
